// File: rtl/sr_seq_pkg.sv
// Shared state encoding for the shift-register configuration sequencer.
package sr_seq_pkg;

  localparam int unsigned StateWidth = 3;

  localparam logic [StateWidth-1:0] StIdleCode = 3'd0;
  localparam logic [StateWidth-1:0] StWr1Code  = 3'd1;
  localparam logic [StateWidth-1:0] StW1Code   = 3'd2;
  localparam logic [StateWidth-1:0] StWr2Code  = 3'd3;
  localparam logic [StateWidth-1:0] StW2Code   = 3'd4;
  localparam logic [StateWidth-1:0] StFinCode  = 3'd5;

  typedef enum logic [StateWidth-1:0] {
    StIdle = StIdleCode,
    StWr1  = StWr1Code,
    StW1   = StW1Code,
    StWr2  = StWr2Code,
    StW2   = StW2Code,
    StFin  = StFinCode
  } sr_seq_state_e;

endpackage

// File: rtl/sr_seq_timer.sv
// Valid-wait counter: cleared before each wait, counts while enabled, flags the last allowed cycle.
module sr_seq_timer #(
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [TO_WIDTH-1:0] limit_i,
  output logic                expired_o
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the timeout entirely.
  assign expired_o = en_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/sr_config_sequencer.sv
// Sequences one shift-register configuration write, with optional verify/retry.
// Define SR_SEQ_VERIFY_EN to build the second write, readback compare and retry logic.
module sr_config_sequencer
  import sr_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 170,
  parameter int unsigned TO_WIDTH   = 16,
  parameter int unsigned RTRY_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [WIDTH-1:0]      cfg_data_i,
  input  logic [RTRY_WIDTH-1:0] max_retry_i,
  input  logic [TO_WIDTH-1:0]   timeout_cycles_i,
  output logic                  sr_start_o,
  output logic [WIDTH-1:0]      sr_din_o,
  input  logic                  sr_valid_i,
  input  logic [WIDTH-1:0]      sr_dout_i,
  output logic [WIDTH-1:0]      old_cfg_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  err_timeout_o,
  output logic                  err_mismatch_o,
  output logic [RTRY_WIDTH-1:0] retry_cnt_o
);

  sr_seq_state_e state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] old_q, old_d;
  logic pass_q, pass_d;
  logic err_to_q, err_to_d;
  logic tmr_clr, tmr_en, tmr_expired;

`ifdef SR_SEQ_VERIFY_EN
  logic [RTRY_WIDTH-1:0] retry_q, retry_d;
  logic [RTRY_WIDTH-1:0] max_retry_q, max_retry_d;
  logic err_mm_q, err_mm_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^max_retry_i;
`endif

  sr_seq_timer #(
    .TO_WIDTH(TO_WIDTH)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .limit_i  (timeout_cycles_i),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    old_d      = old_q;
    pass_d     = pass_q;
    err_to_d   = err_to_q;
`ifdef SR_SEQ_VERIFY_EN
    retry_d     = retry_q;
    max_retry_d = max_retry_q;
    err_mm_d    = err_mm_q;
`endif
    sr_start_o = 1'b0;
    done_o     = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid_i) begin
          pat_d    = cfg_data_i;
          pass_d   = 1'b0;
          err_to_d = 1'b0;
`ifdef SR_SEQ_VERIFY_EN
          max_retry_d = max_retry_i;
          retry_d     = '0;
          err_mm_d    = 1'b0;
`endif
          state_d  = StWr1;
        end
      end
      StWr1: begin
        sr_start_o = 1'b1;
        tmr_clr    = 1'b1;
        state_d    = StW1;
      end
      StW1: begin
        tmr_en = 1'b1;
        // A valid in the timeout cycle still counts as a valid.
        if (sr_valid_i) begin
          old_d = sr_dout_i;
`ifdef SR_SEQ_VERIFY_EN
          state_d = StWr2;
`else
          pass_d  = 1'b1;
          state_d = StFin;
`endif
        end else if (tmr_expired) begin
          err_to_d = 1'b1;
          state_d  = StFin;
        end
      end
`ifdef SR_SEQ_VERIFY_EN
      StWr2: begin
        sr_start_o = 1'b1;
        tmr_clr    = 1'b1;
        state_d    = StW2;
      end
      StW2: begin
        tmr_en = 1'b1;
        if (sr_valid_i) begin
          if (sr_dout_i == pat_q) begin
            pass_d  = 1'b1;
            state_d = StFin;
          end else if (retry_q < max_retry_q) begin
            retry_d = retry_q + 1'b1;
            state_d = StWr2;
          end else begin
            err_mm_d = 1'b1;
            state_d  = StFin;
          end
        end else if (tmr_expired) begin
          err_to_d = 1'b1;
          state_d  = StFin;
        end
      end
`endif
      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      old_q    <= '0;
      pass_q   <= 1'b0;
      err_to_q <= 1'b0;
`ifdef SR_SEQ_VERIFY_EN
      retry_q     <= '0;
      max_retry_q <= '0;
      err_mm_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      old_q    <= old_d;
      pass_q   <= pass_d;
      err_to_q <= err_to_d;
`ifdef SR_SEQ_VERIFY_EN
      retry_q     <= retry_d;
      max_retry_q <= max_retry_d;
      err_mm_q    <= err_mm_d;
`endif
    end
  end

  assign cfg_ready_o   = (state_q == StIdle);
  assign sr_din_o      = pat_q;
  assign old_cfg_o     = old_q;
  assign pass_o        = pass_q;
  assign err_timeout_o = err_to_q;
`ifdef SR_SEQ_VERIFY_EN
  assign retry_cnt_o    = retry_q;
  assign err_mismatch_o = err_mm_q;
`else
  assign retry_cnt_o    = '0;
  assign err_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_sr_config_sequencer.sv
// Directed bench: table of transactions against a behavioural shift-register model.
module tb_sr_config_sequencer;

  localparam int unsigned W  = 170;
  localparam int unsigned TW = 16;
  localparam int unsigned RW = 2;
`ifdef SR_SEQ_VERIFY_EN
  localparam bit Vfy = 1'b1;
`else
  localparam bit Vfy = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]  data;
    logic [RW-1:0] mr;
    logic [TW-1:0] to;
    int            dly;
    int            corrupt;
    bit            never;
    logic [W-1:0]  exp_old;
    bit            exp_pass;
    bit            exp_to;
    bit            exp_mm;
    logic [RW-1:0] exp_retry;
    int            exp_starts;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [W-1:0] cfg_data = '0;
  logic [RW-1:0] max_retry = '0;
  logic [TW-1:0] timeout_cycles = '0;
  logic sr_start;
  logic [W-1:0] sr_din;
  logic sr_valid = 1'b0;
  logic [W-1:0] sr_dout = '0;
  logic [W-1:0] old_cfg;
  logic done, pass, err_timeout, err_mismatch;
  logic [RW-1:0] retry_cnt;

  always #5 clk = ~clk;

  sr_config_sequencer #(
    .WIDTH(W), .TO_WIDTH(TW), .RTRY_WIDTH(RW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_data_i(cfg_data), .max_retry_i(max_retry), .timeout_cycles_i(timeout_cycles),
    .sr_start_o(sr_start), .sr_din_o(sr_din), .sr_valid_i(sr_valid), .sr_dout_i(sr_dout),
    .old_cfg_o(old_cfg), .done_o(done), .pass_o(pass), .err_timeout_o(err_timeout),
    .err_mismatch_o(err_mismatch), .retry_cnt_o(retry_cnt)
  );

  // Shift-register model: each start returns the word held before it, after m_delay cycles.
  int start_total = 0;
  int done_total = 0;
  int m_base = 0, m_delay = 1, m_corrupt = 0;
  bit m_never = 1'b0;
  int cnt = 0;
  logic [W-1:0] shreg = '0;
  logic [W-1:0] pend_q = '0;
  logic [W-1:0] bit0 = W'(1);

  always @(posedge clk) begin
    sr_valid <= 1'b0;
    if (done) done_total <= done_total + 1;
    if (!rst_n) begin
      cnt <= 0;
    end else if (sr_start) begin
      start_total <= start_total + 1;
      if (!m_never) begin
        shreg  <= sr_din;
        cnt    <= m_delay;
        pend_q <= (start_total != m_base && (start_total - m_base) <= m_corrupt) ?
                  (shreg ^ bit0) : shreg;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        sr_valid <= 1'b1;
        sr_dout  <= pend_q;
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [W-1:0] d, input int mr, input int to, input int dly,
                              input int cor, input bit nv, input logic [W-1:0] old,
                              input bit p, input bit t, input bit m, input int rt,
                              input int st);
    vec_t v;
    v.data = d; v.mr = RW'(mr); v.to = TW'(to); v.dly = dly; v.corrupt = cor; v.never = nv;
    v.exp_old = old; v.exp_pass = p; v.exp_to = t; v.exp_mm = m; v.exp_retry = RW'(rt);
    v.exp_starts = st;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n, sb, db, exp_lat;
    bit got;
    m_delay = v.dly; m_corrupt = v.corrupt; m_never = v.never; m_base = start_total;
    sb = start_total; db = done_total;
    @(negedge clk);
    chk({tag, " ready_idle"}, W'(cfg_ready), W'(1));
    cfg_valid = 1'b1; cfg_data = v.data; max_retry = v.mr; timeout_cycles = v.to;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 1; got = 1'b0;
    while (!got && n < 4000) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, " done_seen"}, W'(got), W'(1));
    if (got) begin
      exp_lat = v.exp_to ? 2 + int'(v.to) : 3 + v.dly + (v.exp_starts - 1) * (2 + v.dly);
      chk({tag, " latency"}, W'(n), W'(exp_lat));
      chk({tag, " pass"}, W'(pass), W'(v.exp_pass));
      chk({tag, " err_timeout"}, W'(err_timeout), W'(v.exp_to));
      chk({tag, " err_mismatch"}, W'(err_mismatch), W'(v.exp_mm));
      chk({tag, " retry_cnt"}, W'(retry_cnt), W'(v.exp_retry));
      chk({tag, " old_cfg"}, old_cfg, v.exp_old);
      @(negedge clk);
      chk({tag, " ready_after"}, W'(cfg_ready), W'(1));
      chk({tag, " done_single"}, W'(done_total - db), W'(1));
      chk({tag, " starts"}, W'(start_total - sb), W'(v.exp_starts));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cfg_ready"}, W'(cfg_ready), W'(1));
    chk({tag, " sr_start"}, W'(sr_start), W'(0));
    chk({tag, " done"}, W'(done), W'(0));
    chk({tag, " pass"}, W'(pass), W'(0));
    chk({tag, " err_timeout"}, W'(err_timeout), W'(0));
    chk({tag, " err_mismatch"}, W'(err_mismatch), W'(0));
    chk({tag, " retry_cnt"}, W'(retry_cnt), W'(0));
    chk({tag, " old_cfg"}, old_cfg, '0);
    chk({tag, " sr_din"}, sr_din, '0);
  endtask

  vec_t vecs[8];
  logic [W-1:0] pa, pb, pc;

  initial begin
    int k, db, sb;
    pa = {10{17'h1A5A5}};
    pb = {34{5'b10110}};
    pc = {17{10'h3C9}};
    //              data mr   to  dly cor nv old pass to mm retry starts
    vecs[0] = mk(pa, 0, 1000, 200, 0, 0, '0, 1, 0, 0, 0, Vfy ? 2 : 1);
    vecs[1] = mk(pb, 0, 1000, 200, 0, 0, pa, 1, 0, 0, 0, Vfy ? 2 : 1);
    vecs[2] = mk(pc, 2, 1000, 200, 1, 0, pb, 1, 0, 0, Vfy ? 1 : 0, Vfy ? 3 : 1);
    vecs[3] = mk(pa, 3, 1000, 200, 99, 0, pc, !Vfy, 0, Vfy, Vfy ? 3 : 0, Vfy ? 5 : 1);
    vecs[4] = mk(pb, 0, 50, 1, 0, 1, pc, 0, 1, 0, 0, 1);
    vecs[5] = mk(pc, 0, 100, 99, 0, 0, pa, 1, 0, 0, 0, Vfy ? 2 : 1);
    vecs[6] = mk(pb, 0, 100, 100, 0, 0, pa, 0, 1, 0, 0, 1);
    vecs[7] = mk(pa, 1, 0, 200, 0, 0, pb, 1, 0, 0, 0, Vfy ? 2 : 1);

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for the verify readback (first readback without verify).
    m_delay = 200; m_corrupt = 0; m_never = 1'b0; m_base = start_total;
    sb = start_total; db = done_total;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = pc; max_retry = '0; timeout_cycles = TW'(1000);
    @(negedge clk);
    cfg_valid = 1'b0;
    k = 0;
    while ((start_total - sb) < (Vfy ? 2 : 1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("midrst reach_wait", W'(k < 3000), W'(1));
    repeat (20) @(negedge clk);
    chk("midrst busy", W'(cfg_ready), W'(0));
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst no_done", W'(done_total - db), W'(0));
    run_vec(mk(pb, 0, 1000, 50, 0, 0, pc, 1, 0, 0, 0, Vfy ? 2 : 1), "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
